// File: rtl/mips_ctrl_pkg.sv
// Select encodings shared by the hazard/forwarding controller and the EX/ID muxes.
// Also holds the forwarding-priority helper, so every user applies one rule.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    SEL_BUBBLE = 1'b0,
    SEL_CTRL   = 1'b1
  } stall_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The EX producer is newer than MEM, so it is tested first; $zero never forwards.
  function automatic fwd_sel_e fwd_select(
    input logic       ex_reg_write,
    input logic [4:0] ex_dst,
    input logic       mem_reg_write,
    input logic [4:0] mem_dst,
    input logic [4:0] src
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (ex_reg_write && ex_dst != REG_ZERO && ex_dst == src) begin
      sel = FWD_EX;
    end else if (mem_reg_write && mem_dst != REG_ZERO && mem_dst == src) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_forward_controller_if.sv
// Pipeline-side signal bundle of the hazard/forwarding controller.
// slave is the controller's view, master the view of whoever drives the pipeline.
interface hazard_forward_controller_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_reads_hilo;
  logic       id_redirect;
  logic       idex_mem_read;
  logic       idex_reg_write;
  logic [4:0] idex_dst;
  logic       exmem_reg_write;
  logic [4:0] exmem_dst;
  logic       ex_mdu_start;
  logic [1:0] Ctrl_FwdA;
  logic [1:0] Ctrl_FwdB;
  logic       Ctrl_Mux_Select_Stall;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       mdu_busy;

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_reads_hilo, id_redirect,
           idex_mem_read, idex_reg_write, idex_dst, exmem_reg_write, exmem_dst,
           ex_mdu_start,
    output Ctrl_FwdA, Ctrl_FwdB, Ctrl_Mux_Select_Stall, pc_write, ifid_write,
           ifid_flush, mdu_busy
  );

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_reads_hilo, id_redirect,
           idex_mem_read, idex_reg_write, idex_dst, exmem_reg_write, exmem_dst,
           ex_mdu_start,
    input  Ctrl_FwdA, Ctrl_FwdB, Ctrl_Mux_Select_Stall, pc_write, ifid_write,
           ifid_flush, mdu_busy
  );
endinterface

// File: rtl/hazard_forward_controller_mdu_busy_counter.sv
// Tracks how many more cycles the multiply/divide unit keeps HI/LO busy.
// A start reloads the full latency even if a previous operation is still running.
module mdu_busy_counter #(
  parameter int unsigned MDU_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic [3:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (start) begin
      count <= 4'(MDU_LATENCY);
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign busy = (count != 4'd0);

endmodule

// File: rtl/hazard_forward_controller.sv
// ID-stage hazard detection (load-use, HI/LO) with PC/IF-ID freeze and redirect flush,
// plus the registered EX-stage forwarding selects.
module hazard_forward_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 4
) (
  input logic                          clk,
  input logic                          reset,
  hazard_forward_controller_if.slave   bus
);

  logic       load_use;
  logic       hilo_hazard;
  logic       stall;
  logic       mdu_busy;
  logic [3:0] mdu_cnt;
  fwd_sel_e   fwd_a;
  fwd_sel_e   fwd_b;
  stall_sel_e stall_sel;

  mdu_busy_counter #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_busy_counter (
    .clk  (clk),
    .reset(reset),
    .start(bus.ex_mdu_start),
    .busy (mdu_busy),
    .count(mdu_cnt)
  );

  // A start in EX counts as busy already, so mfhi right behind mult stalls that same cycle.
  always_comb begin
    load_use    = bus.idex_mem_read && (bus.idex_dst != REG_ZERO) &&
                  ((bus.id_use_rs && bus.id_rs == bus.idex_dst) ||
                   (bus.id_use_rt && bus.id_rt == bus.idex_dst));
    hilo_hazard = bus.id_reads_hilo && (mdu_busy || bus.ex_mdu_start);
    stall       = load_use || hilo_hazard;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.ifid_flush = bus.id_redirect;
    stall_sel      = SEL_CTRL;
    if (stall) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b0;
      stall_sel      = SEL_BUBBLE;
    end
  end

  // A stalled cycle pushes a bubble into EX, which must not forward anything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else if (stall) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else begin
      fwd_a <= fwd_select(bus.idex_reg_write, bus.idex_dst,
                          bus.exmem_reg_write, bus.exmem_dst, bus.id_rs);
      fwd_b <= fwd_select(bus.idex_reg_write, bus.idex_dst,
                          bus.exmem_reg_write, bus.exmem_dst, bus.id_rt);
    end
  end

  assign bus.Ctrl_FwdA             = fwd_a;
  assign bus.Ctrl_FwdB             = fwd_b;
  assign bus.Ctrl_Mux_Select_Stall = stall_sel;
  assign bus.mdu_busy              = mdu_busy;

  cnt_in_range : assert property (@(posedge clk) disable iff (reset)
    mdu_cnt <= 4'(MDU_LATENCY));

endmodule

// File: tb/tb_hazard_forward_controller.sv
// Scoreboard bench: stimulus pushes expected outputs from a cycle-level model into a
// queue; a negedge monitor pops and compares whatever the controller presents.
module tb_hazard_forward_controller;

  localparam int LAT = 4;

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, reads_hilo, redirect;
    logic       mem_read, ex_wr;
    logic [4:0] ex_dst;
    logic       mem_wr;
    logic [4:0] mem_dst;
    logic       start;
  } stim_t;

  typedef struct {
    int cyc;
    int run;
    int flush;
    int fa;
    int fb;
    int busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  hazard_forward_controller_if bus ();

  hazard_forward_controller #(.MDU_LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_start = -1000;
  int   nfa = 0;
  int   nfb = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rs: 5'd0, rt: 5'd0, use_rs: 1'b0, use_rt: 1'b0, reads_hilo: 1'b0,
          redirect: 1'b0, mem_read: 1'b0, ex_wr: 1'b0, ex_dst: 5'd0,
          mem_wr: 1'b0, mem_dst: 5'd0, start: 1'b0};
    return s;
  endfunction

  function automatic int src_sel(input stim_t s, input logic [4:0] src);
    if (s.ex_wr && s.ex_dst != 0 && s.ex_dst == src) return 1;
    if (s.mem_wr && s.mem_dst != 0 && s.mem_dst == src) return 2;
    return 0;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rs           = s.rs;
    bus.id_rt           = s.rt;
    bus.id_use_rs       = s.use_rs;
    bus.id_use_rt       = s.use_rt;
    bus.id_reads_hilo   = s.reads_hilo;
    bus.id_redirect     = s.redirect;
    bus.idex_mem_read   = s.mem_read;
    bus.idex_reg_write  = s.ex_wr;
    bus.idex_dst        = s.ex_dst;
    bus.exmem_reg_write = s.mem_wr;
    bus.exmem_dst       = s.mem_dst;
    bus.ex_mdu_start    = s.start;
  endtask

  // One pipeline cycle: drive just after the edge, predict this cycle's outputs.
  task automatic step(input stim_t s);
    exp_t e;
    bit busy, lu, hz, stall;
    @(posedge clk);
    #1;
    apply(s);
    busy  = (cyc - last_start >= 1) && (cyc - last_start <= LAT);
    lu    = s.mem_read && s.ex_dst != 0 &&
            ((s.use_rs && s.rs == s.ex_dst) || (s.use_rt && s.rt == s.ex_dst));
    hz    = s.reads_hilo && (busy || s.start);
    stall = lu || hz;
    e.cyc   = cyc;
    e.run   = stall ? 0 : 1;
    e.flush = (!stall && s.redirect) ? 1 : 0;
    e.fa    = nfa;
    e.fb    = nfb;
    e.busy  = busy ? 1 : 0;
    q.push_back(e);
    nfa = stall ? 0 : src_sel(s, s.rs);
    nfb = stall ? 0 : src_sel(s, s.rt);
    if (s.start) last_start = cyc;
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check($sformatf("pc_write c%0d", e.cyc), int'(bus.pc_write), e.run);
        check($sformatf("ifid_write c%0d", e.cyc), int'(bus.ifid_write), e.run);
        check($sformatf("stall_sel c%0d", e.cyc), int'(bus.Ctrl_Mux_Select_Stall), e.run);
        check($sformatf("ifid_flush c%0d", e.cyc), int'(bus.ifid_flush), e.flush);
        check($sformatf("fwd_a c%0d", e.cyc), int'(bus.Ctrl_FwdA), e.fa);
        check($sformatf("fwd_b c%0d", e.cyc), int'(bus.Ctrl_FwdB), e.fb);
        check($sformatf("mdu_busy c%0d", e.cyc), int'(bus.mdu_busy), e.busy);
      end
    end
  end

  // Asserts reset between edges (after the monitor has sampled) and checks it acts at once.
  task automatic mid_cycle_reset(input string tag);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check({tag, " fwd_a"}, int'(bus.Ctrl_FwdA), 0);
    check({tag, " fwd_b"}, int'(bus.Ctrl_FwdB), 0);
    check({tag, " mdu_busy"}, int'(bus.mdu_busy), 0);
    check({tag, " pc_write"}, int'(bus.pc_write), 1);
    last_start = -1000;
    nfa = 0;
    nfb = 0;
    @(posedge clk);
    #2;
    apply(idle());
    reset = 1'b0;
  endtask

  initial begin : stimulus
    stim_t s;
    apply(idle());
    repeat (2) @(posedge clk);
    #2;
    check("reset fwd_a", int'(bus.Ctrl_FwdA), 0);
    check("reset fwd_b", int'(bus.Ctrl_FwdB), 0);
    check("reset mdu_busy", int'(bus.mdu_busy), 0);
    reset = 1'b0;
    step(idle());
    step(idle());

    // Load-use on rs; the load also writes, yet the stall edge must load FWD_REG.
    s = idle();
    s.mem_read = 1'b1; s.ex_wr = 1'b1; s.ex_dst = 5'd8; s.rs = 5'd8; s.use_rs = 1'b1;
    step(s);
    s.mem_read = 1'b0; s.ex_wr = 1'b0;
    step(s);

    // Forwarding priority: EX over MEM, then MEM alone, then $zero.
    s = idle();
    s.ex_wr = 1'b1; s.ex_dst = 5'd5; s.mem_wr = 1'b1; s.mem_dst = 5'd5;
    s.rs = 5'd5; s.rt = 5'd5;
    step(s);
    s.ex_wr = 1'b0;
    step(s);
    s.ex_wr = 1'b1; s.ex_dst = 5'd0; s.mem_dst = 5'd0; s.rs = 5'd0; s.rt = 5'd0;
    step(s);
    step(idle());

    // mult then mfhi held; later a restart while the count reads 2.
    s = idle();
    s.start = 1'b1; s.reads_hilo = 1'b1;
    step(s);
    s.start = 1'b0;
    repeat (6) step(s);
    s = idle();
    s.start = 1'b1;
    step(s);
    s.start = 1'b0;
    repeat (2) step(s);
    s.start = 1'b1;
    step(s);
    s.start = 1'b0; s.reads_hilo = 1'b1;
    repeat (6) step(s);

    // Redirect alone flushes; with a load-use the stall wins; then it flushes.
    s = idle();
    s.redirect = 1'b1;
    step(s);
    s.mem_read = 1'b1; s.ex_dst = 5'd9; s.rt = 5'd9; s.use_rt = 1'b1;
    step(s);
    s.mem_read = 1'b0;
    step(s);
    step(idle());

    // Reset while a forward select is live.
    s = idle();
    s.ex_wr = 1'b1; s.ex_dst = 5'd5; s.rs = 5'd5; s.rt = 5'd5;
    step(s);
    step(idle());
    mid_cycle_reset("rst_fwd");

    // Reset mid HI/LO stall with the counter at 3, mfhi still in ID.
    s = idle();
    s.start = 1'b1; s.reads_hilo = 1'b1;
    step(s);
    s.start = 1'b0;
    repeat (2) step(s);
    mid_cycle_reset("rst_mdu");
    step(idle());

    for (int i = 0; i < 400; i++) begin
      s.rs         = 5'($urandom_range(0, 3));
      s.rt         = 5'($urandom_range(0, 3));
      s.use_rs     = 1'($urandom_range(0, 1));
      s.use_rt     = 1'($urandom_range(0, 1));
      s.reads_hilo = ($urandom_range(0, 2) == 0);
      s.redirect   = ($urandom_range(0, 3) == 0);
      s.mem_read   = ($urandom_range(0, 2) == 0);
      s.ex_wr      = 1'($urandom_range(0, 1));
      s.ex_dst     = 5'($urandom_range(0, 3));
      s.mem_wr     = 1'($urandom_range(0, 1));
      s.mem_dst    = 5'($urandom_range(0, 3));
      s.start      = ($urandom_range(0, 7) == 0);
      step(s);
    end
    step(idle());

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
